// File: rtl/hilo_acc_reg.sv
// HI/LO register pair with direct write ports and a two-step multiply-accumulate
// (LO half first, then HI half with the carry or borrow from the LO step).
module hilo_acc_reg #(
   parameter int unsigned           DATA_W    = 32,
   parameter logic [DATA_W-1:0]     RESET_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we_hi,
   input  logic                     we_lo,
   input  logic [DATA_W-1:0]        hi_i,
   input  logic [DATA_W-1:0]        lo_i,
   input  logic                     acc_valid,
   input  logic                     acc_sub,
   input  logic [2*DATA_W-1:0]      prod_i,
   output logic                     acc_ready,
   output logic                     busy,
   output logic                     acc_done,
   output logic [DATA_W-1:0]        hi_o,
   output logic [DATA_W-1:0]        lo_o,
   output logic [1:0]               dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACC_LO = 2'd1,
      ACC_HI = 2'd2
   } state_t;

   state_t                 state, state_n;
   logic [DATA_W-1:0]      hi_q, lo_q;
   logic [2*DATA_W-1:0]    prod_q;
   logic                   sub_q;
   logic                   carry_q;
   logic                   done_q;
   logic                   accept;
   logic [DATA_W:0]        lo_sum;
   logic [DATA_W-1:0]      hi_sum;

   // Handshake: an accumulate transfers at the rising edge where acc_valid and
   // acc_ready are both high; acc_ready is low whenever a direct write is
   // requested or an accumulate is in flight, so the requester must hold
   // acc_valid (and prod_i/acc_sub) until that edge.
   assign acc_ready = (state == IDLE) && !we_hi && !we_lo;
   assign accept    = acc_valid && acc_ready;
   assign busy      = (state != IDLE);
   assign acc_done  = done_q;
   assign hi_o      = hi_q;
   assign lo_o      = lo_q;
   assign dbg_state = state;

   // Bit DATA_W of the widened LO result is the carry-out for add and the
   // borrow-out for subtract.
   always_comb begin
      lo_sum = '0;
      hi_sum = '0;
      if (sub_q) begin
         lo_sum = {1'b0, lo_q} - {1'b0, prod_q[DATA_W-1:0]};
         hi_sum = hi_q - prod_q[2*DATA_W-1:DATA_W] - DATA_W'(carry_q);
      end else begin
         lo_sum = {1'b0, lo_q} + {1'b0, prod_q[DATA_W-1:0]};
         hi_sum = hi_q + prod_q[2*DATA_W-1:DATA_W] + DATA_W'(carry_q);
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = ACC_LO;
         ACC_LO:  state_n = ACC_HI;
         ACC_HI:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         hi_q    <= RESET_VAL;
         lo_q    <= RESET_VAL;
         prod_q  <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state  <= state_n;
         done_q <= (state == ACC_HI);
         case (state)
            IDLE: begin
               if (we_hi) hi_q <= hi_i;
               if (we_lo) lo_q <= lo_i;
               if (accept) begin
                  prod_q <= prod_i;
                  sub_q  <= acc_sub;
               end
            end
            ACC_LO: begin
               lo_q    <= lo_sum[DATA_W-1:0];
               carry_q <= lo_sum[DATA_W];
            end
            ACC_HI: begin
               hi_q    <= hi_sum;
               carry_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_acc_reg.sv
// Directed bench for hilo_acc_reg: reset, direct writes, add/sub accumulates,
// back-to-back issue, write/accumulate conflicts and reset abort.
module tb_hilo_acc_reg;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          we_hi, we_lo;
   logic [W-1:0]  hi_i, lo_i;
   logic          acc_valid, acc_sub;
   logic [2*W-1:0] prod_i;
   logic          acc_ready, busy, acc_done;
   logic [W-1:0]  hi_o, lo_o;
   logic [1:0]    dbg_state;

   int errors = 0;
   int checks = 0;

   hilo_acc_reg #(.DATA_W(W), .RESET_VAL('0)) dut (
      .clk(clk), .rst(rst), .we_hi(we_hi), .we_lo(we_lo),
      .hi_i(hi_i), .lo_i(lo_i), .acc_valid(acc_valid), .acc_sub(acc_sub),
      .prod_i(prod_i), .acc_ready(acc_ready), .busy(busy), .acc_done(acc_done),
      .hi_o(hi_o), .lo_o(lo_o), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [W-1:0] h, input logic [W-1:0] l);
      we_hi = 1'b1; we_lo = 1'b1; hi_i = h; lo_i = l;
      tick();
      we_hi = 1'b0; we_lo = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #2;
      checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", hi_o, 32'h0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (acc_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", acc_done); end
      tick();
      rst = 1'b1;
      load(32'hCAFE0001, 32'hCAFE0002);
      checks++; if (lo_o !== 32'hCAFE0002) begin errors++; $display("FAIL preload_lo: got %h expected %h", lo_o, 32'hCAFE0002); end
      // Mid-cycle asynchronous assertion
      #3 rst = 1'b0;
      #1;
      checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL async_hi: got %h expected %h", hi_o, 32'h0); end
      checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL async_lo: got %h expected %h", lo_o, 32'h0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b expected 0", busy); end
      tick();
      rst = 1'b1;
   endtask

   task automatic test_direct_write;
      we_hi = 1'b1; hi_i = 32'h12345678;
      tick();
      we_hi = 1'b0;
      checks++; if (hi_o !== 32'h12345678) begin errors++; $display("FAIL dw_hi: got %h expected %h", hi_o, 32'h12345678); end
      checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL dw_lo_hold: got %h expected %h", lo_o, 32'h0); end
      we_lo = 1'b1; lo_i = 32'h9ABCDEF0;
      tick();
      we_lo = 1'b0;
      checks++; if (lo_o !== 32'h9ABCDEF0) begin errors++; $display("FAIL dw_lo: got %h expected %h", lo_o, 32'h9ABCDEF0); end
      checks++; if (hi_o !== 32'h12345678) begin errors++; $display("FAIL dw_hi_hold: got %h expected %h", hi_o, 32'h12345678); end
   endtask

   task automatic test_add_carry;
      int done_cnt;
      int busy_cnt;
      done_cnt = 0; busy_cnt = 0;
      load(32'h0, 32'hFFFFFFFF);
      acc_valid = 1'b1; acc_sub = 1'b0; prod_i = 64'h1;
      #1;
      checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b expected 1", acc_ready); end
      tick();
      acc_valid = 1'b0;
      checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL add_state_lo: got %0d expected 1", dbg_state); end
      checks++; if (lo_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL add_lo_pre: got %h expected %h", lo_o, 32'hFFFFFFFF); end
      if (busy) busy_cnt++;
      tick();
      checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL add_lo_edge1: got %h expected %h", lo_o, 32'h0); end
      checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL add_hi_edge1: got %h expected %h", hi_o, 32'h0); end
      if (busy) busy_cnt++;
      if (acc_done) done_cnt++;
      tick();
      checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL add_hi_edge2: got %h expected %h", hi_o, 32'h1); end
      checks++; if (acc_done !== 1'b1) begin errors++; $display("FAIL add_done: got %b expected 1", acc_done); end
      if (busy) busy_cnt++;
      if (acc_done) done_cnt++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (acc_done) done_cnt++;
         if (busy) busy_cnt++;
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL add_done_count: got %0d expected 1", done_cnt); end
      checks++; if (busy_cnt != 2) begin errors++; $display("FAIL add_busy_count: got %0d expected 2", busy_cnt); end
   endtask

   task automatic test_sub_borrow;
      load(32'h0, 32'h0);
      acc_valid = 1'b1; acc_sub = 1'b1; prod_i = 64'h1;
      tick();
      acc_valid = 1'b0;
      tick();
      checks++; if (lo_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL sub_lo: got %h expected %h", lo_o, 32'hFFFFFFFF); end
      tick();
      checks++; if (hi_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL sub_hi: got %h expected %h", hi_o, 32'hFFFFFFFF); end
      checks++; if (acc_done !== 1'b1) begin errors++; $display("FAIL sub_done: got %b expected 1", acc_done); end
   endtask

   // Entered in the acc_done cycle of the subtract above (HI:LO = all ones)
   task automatic test_back_to_back;
      acc_valid = 1'b1; acc_sub = 1'b0; prod_i = 64'h0000_0001_0000_0002;
      #1;
      checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", acc_ready); end
      tick();
      acc_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
      tick();
      tick();
      checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL b2b_hi: got %h expected %h", hi_o, 32'h1); end
      checks++; if (lo_o !== 32'h1) begin errors++; $display("FAIL b2b_lo: got %h expected %h", lo_o, 32'h1); end
      tick();
   endtask

   task automatic test_conflict;
      acc_valid = 1'b1; acc_sub = 1'b0; prod_i = 64'h1;
      we_lo = 1'b1; lo_i = 32'hAAAA5555;
      #1;
      checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL cf_ready: got %b expected 0", acc_ready); end
      tick();
      we_lo = 1'b0;
      checks++; if (lo_o !== 32'hAAAA5555) begin errors++; $display("FAIL cf_lo_write: got %h expected %h", lo_o, 32'hAAAA5555); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cf_not_accepted: got %b expected 0", busy); end
      tick();
      acc_valid = 1'b0;
      we_hi = 1'b1; hi_i = 32'hDEADBEEF;
      tick();
      checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL cf_hi_busy_lo: got %h expected %h", hi_o, 32'h1); end
      tick();
      we_hi = 1'b0;
      checks++; if (hi_o !== 32'h1) begin errors++; $display("FAIL cf_hi_final: got %h expected %h", hi_o, 32'h1); end
      checks++; if (lo_o !== 32'hAAAA5556) begin errors++; $display("FAIL cf_lo_final: got %h expected %h", lo_o, 32'hAAAA5556); end
      tick();
   endtask

   task automatic test_abort;
      load(32'h11111111, 32'h22222222);
      acc_valid = 1'b1; acc_sub = 1'b0; prod_i = 64'h0000_0001_0000_0001;
      tick();
      acc_valid = 1'b0;
      tick();
      checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL abort_in_hi: got %0d expected 2", dbg_state); end
      #2 rst = 1'b0;
      #1;
      checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin errors++; $display("FAIL abort_clear: got %h:%h expected 0:0", hi_o, lo_o); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      tick();
      checks++; if (acc_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", acc_done); end
      rst = 1'b1;
      tick();
      checks++; if (acc_done !== 1'b0) begin errors++; $display("FAIL abort_done_after: got %b expected 0", acc_done); end
      acc_valid = 1'b1; acc_sub = 1'b0; prod_i = 64'h0000_0002_0000_0003;
      tick();
      acc_valid = 1'b0;
      tick();
      tick();
      checks++; if (hi_o !== 32'h2 || lo_o !== 32'h3) begin errors++; $display("FAIL abort_resume: got %h:%h expected 2:3", hi_o, lo_o); end
      checks++; if (acc_done !== 1'b1) begin errors++; $display("FAIL abort_resume_done: got %b expected 1", acc_done); end
   endtask

   initial begin
      we_hi = 1'b0; we_lo = 1'b0; hi_i = '0; lo_i = '0;
      acc_valid = 1'b0; acc_sub = 1'b0; prod_i = '0;
      test_reset();
      test_direct_write();
      test_add_carry();
      test_sub_borrow();
      test_back_to_back();
      test_conflict();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
